// File: rtl/f3m_mult_serial.sv
// Coefficient-serial GF(3^M) multiplier, reduction polynomial x^M + x^K + 2, start/done handshake.
// Define F3M_MULT_DIGIT2_EN to consume two B coefficients per RUN cycle.
module f3m_mult_serial #(
  parameter int M = 97,
  parameter int K = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*M-1:0] A,
  input  logic [2*M-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] C
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  // Handshake: start is sampled only in IDLE or FIN; done is a one-cycle pulse with C valid.
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state, state_nx;
  logic [2*M-1:0] a_q, a_nx, b_q, b_nx, acc_q, acc_nx, c_q, c_nx, step_res;
  logic [CW-1:0]  cnt_q, cnt_nx;
  logic           last;

  function automatic logic [1:0] f3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] f3_neg(input logic [1:0] x);
    return (x == 2'd1) ? 2'd2 : (x == 2'd2) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] f3_mult(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd0 || y == 2'd0) return 2'd0;
    return (x == y) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [1:0] coef(input logic [2*M-1:0] v, input logic [CW-1:0] idx);
    logic [2*M-1:0] s;
    s = v >> {idx, 1'b0};
    return s[1:0];
  endfunction

  // acc*x mod p: x^M folds back as 2x^K + 1, then add bi*A coefficient-wise.
  function automatic logic [2*M-1:0] mac_step(input logic [2*M-1:0] acc,
                                              input logic [2*M-1:0] a,
                                              input logic [1:0]     bi);
    logic [2*M-1:0] r;
    logic [1:0]     t;
    t = acc[2*M-1 -: 2];
    r = {acc[2*M-3:0], t};
    r[2*K +: 2] = f3_add(r[2*K +: 2], f3_neg(t));
    for (int j = 0; j < M; j++)
      r[2*j +: 2] = f3_add(r[2*j +: 2], f3_mult(bi, a[2*j +: 2]));
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      acc_q <= acc_nx;
      c_q   <= c_nx;
      cnt_q <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    acc_nx   = acc_q;
    c_nx     = c_q;
    cnt_nx   = cnt_q;
    step_res = '0;
    last     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        busy = 1'b1;
`ifdef F3M_MULT_DIGIT2_EN
        // With odd M the top coefficient is handled alone so the rest pair up evenly.
        if ((M % 2 == 1) && cnt_q == CW'(M - 1)) begin
          step_res = mac_step(acc_q, a_q, coef(b_q, cnt_q));
          last     = (cnt_q == '0);
          cnt_nx   = cnt_q - CW'(1);
        end else begin
          step_res = mac_step(mac_step(acc_q, a_q, coef(b_q, cnt_q)),
                              a_q, coef(b_q, cnt_q - CW'(1)));
          last     = (cnt_q == CW'(1));
          cnt_nx   = cnt_q - CW'(2);
        end
`else
        step_res = mac_step(acc_q, a_q, coef(b_q, cnt_q));
        last     = (cnt_q == '0);
        cnt_nx   = cnt_q - CW'(1);
`endif
        acc_nx = step_res;
        if (last) begin
          c_nx     = step_res;
          cnt_nx   = '0;
          state_nx = FIN;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: ;
    endcase
    if ((state == IDLE || state == FIN) && start) begin
      a_nx     = A;
      b_nx     = B;
      acc_nx   = '0;
      cnt_nx   = CW'(M - 1);
      state_nx = RUN;
    end
  end

  assign C = c_q;

endmodule

// File: tb/tb_f3m_mult_serial.sv
// Directed and randomized checks of f3m_mult_serial against hand-computed values and a GF(3) polynomial model.
module tb_f3m_mult_serial;

  localparam int M = 97;
  localparam int K = 12;
`ifdef F3M_MULT_DIGIT2_EN
  localparam int LAT = (M + 1) / 2;
`else
  localparam int LAT = M;
`endif
  localparam int TIMEOUT = 400;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2*M-1:0] A, B;
  logic           busy, done;
  logic [2*M-1:0] C;

  int n_checks = 0;
  int n_fails  = 0;

  f3m_mult_serial #(.M(M), .K(K)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .C(C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*M-1:0] obs, input logic [2*M-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*M-1:0] mono(input int idx, input logic [1:0] val);
    logic [2*M-1:0] v;
    v = '0;
    v[2*idx +: 2] = val;
    return v;
  endfunction

  function automatic logic [2*M-1:0] all_coef(input logic [1:0] val);
    logic [2*M-1:0] v;
    for (int i = 0; i < M; i++) v[2*i +: 2] = val;
    return v;
  endfunction

  function automatic logic [2*M-1:0] rand_elem();
    logic [2*M-1:0] v;
    for (int i = 0; i < M; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
    return v;
  endfunction

  // Schoolbook product, then fold degrees >= M using x^M = 2x^K + 1.
  function automatic logic [2*M-1:0] model_mult(input logic [2*M-1:0] a, input logic [2*M-1:0] b);
    int p[2*M-1];
    logic [2*M-1:0] r;
    for (int i = 0; i < 2*M-1; i++) p[i] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        p[i+j] = (p[i+j] + int'(a[2*i +: 2]) * int'(b[2*j +: 2])) % 3;
    for (int n = 2*M-2; n >= M; n--) begin
      p[n-M+K] = (p[n-M+K] + 2 * p[n]) % 3;
      p[n-M]   = (p[n-M] + p[n]) % 3;
      p[n]     = 0;
    end
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(p[i]);
    return r;
  endfunction

  function automatic logic has_code3(input logic [2*M-1:0] v);
    for (int i = 0; i < M; i++) if (v[2*i +: 2] == 2'd3) return 1'b1;
    return 1'b0;
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic start_op(input logic [2*M-1:0] a, input logic [2*M-1:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = mono(5, 2'd2);
    B = all_coef(2'd1);
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [2*M-1:0] a,
                           input logic [2*M-1:0] b, input logic [2*M-1:0] exp);
    int lat, nbusy;
    start_op(a, b);
    wait_done(lat, nbusy);
    check({tag, "_lat"}, 2*M'(lat), 2*M'(LAT));
    check({tag, "_c"}, C, exp);
    @(negedge clk);
  endtask

  initial begin
    int lat, nbusy, ndone;
    logic [2*M-1:0] ra, rb, exp_c;

    reset = 1'b0;
    start = 1'b1;
    A = all_coef(2'd1);
    B = all_coef(2'd2);
    repeat (3) @(negedge clk);
    check("rst_busy", 2*M'(busy), '0);
    check("rst_done", 2*M'(done), '0);
    check("rst_c", C, '0);

    reset = 1'b1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 2*M'(busy), '0);
    check("idle_done", 2*M'(done), '0);
    check("idle_c", C, '0);

    // 1 * x = x, with exact latency and busy length
    start_op(mono(0, 2'd1), mono(1, 2'd1));
    wait_done(lat, nbusy);
    check("basic_lat", 2*M'(lat), 2*M'(LAT));
    check("basic_busy", 2*M'(nbusy), 2*M'(LAT));
    check("basic_c", C, mono(1, 2'd1));
    @(negedge clk);
    check("basic_done_clr", 2*M'(done), '0);
    check("basic_busy_clr", 2*M'(busy), '0);

    // x^96 * x = x^97 = 2x^12 + 1
    run_check("reduce", mono(96, 2'd1), mono(1, 2'd1), mono(12, 2'd2) | mono(0, 2'd1));
    run_check("two_two", mono(0, 2'd2), mono(0, 2'd2), mono(0, 2'd1));
    run_check("zero_a", '0, all_coef(2'd2), '0);
    run_check("ones_b1", all_coef(2'd1), mono(0, 2'd1), all_coef(2'd1));

    // start mid-RUN is ignored: x^2 * x^3 = x^5
    start_op(mono(2, 2'd1), mono(3, 2'd1));
    repeat (20) @(negedge clk);
    A = all_coef(2'd1);
    B = mono(0, 2'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nbusy);
    check("ign_lat", 2*M'(lat + 21), 2*M'(LAT));
    check("ign_c", C, mono(5, 2'd1));
    ndone = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("ign_single_done", 2*M'(ndone), '0);

    // start during done cycle: x^96 * x^2 = 2x^13 + x
    start_op(mono(0, 2'd2), mono(0, 2'd1));
    wait_done(lat, nbusy);
    check("b2b_first_c", C, mono(0, 2'd2));
    start_op(mono(96, 2'd1), mono(2, 2'd1));
    check("b2b_done_clr", 2*M'(done), '0);
    check("b2b_busy", 2*M'(busy), 2*M'(1));
    wait_done(lat, nbusy);
    check("b2b_lat", 2*M'(lat), 2*M'(LAT));
    check("b2b_c", C, mono(13, 2'd2) | mono(1, 2'd1));
    @(negedge clk);

    // reset during iteration 40 aborts with no done
    start_op(all_coef(2'd2), all_coef(2'd1));
    repeat (39) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 2*M'(busy), '0);
    check("abort_done", 2*M'(done), '0);
    check("abort_c", C, '0);
    reset = 1'b1;
    ndone = 0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", 2*M'(ndone), '0);
    check("abort_c_hold", C, '0);

    for (int n = 0; n < 200; n++) begin
      ra = rand_elem();
      rb = rand_elem();
      exp_c = model_mult(ra, rb);
      start_op(ra, rb);
      wait_done(lat, nbusy);
      check($sformatf("rand%0d_c", n), C, exp_c);
      check($sformatf("rand%0d_code3", n), 2*M'(has_code3(C)), '0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
